// File: rtl/stepdown_pwm_deadtime_ctrl.sv
// rtl/stepdown_pwm_deadtime_ctrl.sv - step-down PWM controller with current-limit exit and dead time
// Outputs are registered and decoded from the next state, so they move on the same edge as the state.
module stepdown_pwm_deadtime_ctrl #(
    parameter int CNT_W   = 8,
    parameter int MAX_ON  = 200,
    parameter int MIN_ON  = 4,
    parameter int MIN_OFF = 4,
    parameter int DEAD    = 2,
    parameter int LEB     = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic       period_start,
    input  logic       ilim_trip,
    output logic       hs_on,
    output logic       ls_on,
    output logic       pwm_o,
    output logic       maxduty_p,
    output logic [7:0] skip_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_OFF   = 3'd1;
    localparam logic [2:0] S_DT_HL = 3'd2;
    localparam logic [2:0] S_ON    = 3'd3;
    localparam logic [2:0] S_DT_LH = 3'd4;

    // Trip is honoured only once both the blanking window and the minimum on-time have elapsed.
    localparam int TRIP_MIN_I = (LEB > MIN_ON - 1) ? LEB : MIN_ON - 1;

    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] OFF_MIN   = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] DEAD_END  = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] ON_MAX    = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] TRIP_MIN  = CNT_W'(TRIP_MIN_I);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs_on_q, hs_on_d;
    logic             ls_on_q, ls_on_d;
    logic             maxduty_q, maxduty_d;
    logic [7:0]       skip_q, skip_d;
    logic             ilim_meta_q, ilim_s_q;

    logic unused_pins;
    assign unused_pins = ^{CELV, CELG, SUB};

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        maxduty_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_OFF;
            end
            S_OFF: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (period_start) begin
                    if (cnt_q >= OFF_MIN) state_d = S_DT_HL;
                    else if (skip_q != 8'hFF) skip_d = skip_q + 8'd1;
                end
            end
            S_DT_HL: begin
                if (!en) state_d = S_IDLE;
                else if (cnt_q == DEAD_END) state_d = S_ON;
            end
            S_ON: begin
                if (cnt_q == ON_MAX) maxduty_d = 1'b1;
                if (!en || (ilim_s_q && cnt_q >= TRIP_MIN) || cnt_q == ON_MAX) state_d = S_DT_LH;
            end
            S_DT_LH: begin
                if (cnt_q == DEAD_END) state_d = en ? S_OFF : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
        else cnt_d = cnt_q + CNT_W'(1);

        hs_on_d = (state_d == S_ON);
        ls_on_d = (state_d == S_OFF);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hs_on_q     <= 1'b0;
            ls_on_q     <= 1'b0;
            maxduty_q   <= 1'b0;
            skip_q      <= 8'd0;
            ilim_meta_q <= 1'b0;
            ilim_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hs_on_q     <= hs_on_d;
            ls_on_q     <= ls_on_d;
            maxduty_q   <= maxduty_d;
            skip_q      <= skip_d;
            ilim_meta_q <= ilim_trip;
            ilim_s_q    <= ilim_meta_q;
        end
    end

    assign hs_on     = hs_on_q;
    assign pwm_o     = hs_on_q;
    assign ls_on     = ls_on_q;
    assign maxduty_p = maxduty_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_stepdown_pwm_deadtime_ctrl.sv
// tb/tb_stepdown_pwm_deadtime_ctrl.sv - self-checking bench for stepdown_pwm_deadtime_ctrl
// Phase/time-in-phase reference model stepped every clock, plus directed pulse-width checks.
module tb_stepdown_pwm_deadtime_ctrl;

    localparam int MAX_ON = 200, MIN_ON = 4, MIN_OFF = 4, DEAD = 2, LEB = 3;

    logic       CLK = 1'b0, RST = 1'b1;
    logic       en = 1'b0, period_start = 1'b0, ilim_trip = 1'b0;
    logic       hs_on, ls_on, pwm_o, maxduty_p;
    logic [7:0] skip_cnt;

    stepdown_pwm_deadtime_ctrl dut (
        .CLK(CLK), .RST(RST), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .period_start(period_start), .ilim_trip(ilim_trip),
        .hs_on(hs_on), .ls_on(ls_on), .pwm_o(pwm_o), .maxduty_p(maxduty_p), .skip_cnt(skip_cnt)
    );

    always #5 CLK = ~CLK;

    typedef enum int {P_IDLE, P_OFF, P_GAP_UP, P_ON, P_GAP_DN} m_phase_t;

    m_phase_t m_phase = P_IDLE;
    int       m_t = 0, m_skip = 0;
    bit       m_hs = 0, m_ls = 0, m_max = 0;
    bit       trip_hist[$] = '{1'b0, 1'b0};

    int checks = 0, passed = 0;
    int gap_run = 0, last_gap = 0, hs_run = 0, last_hs = 0, max_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else passed++;
    endtask

    task automatic model_step();
        m_phase_t nxt;
        bit       ilim_s;
        m_max = 0;
        if (RST) begin
            m_phase = P_IDLE; m_t = 0; m_skip = 0; m_hs = 0; m_ls = 0;
            trip_hist.delete();
            trip_hist.push_back(1'b0);
            trip_hist.push_back(1'b0);
            return;
        end
        ilim_s = trip_hist.pop_front();
        trip_hist.push_back(ilim_trip);
        nxt = m_phase;
        case (m_phase)
            P_IDLE:   if (en) nxt = P_OFF;
            P_OFF: begin
                if (!en) nxt = P_IDLE;
                else if (period_start) begin
                    if (m_t >= MIN_OFF - 1) nxt = P_GAP_UP;
                    else if (m_skip < 255) m_skip++;
                end
            end
            P_GAP_UP: begin
                if (!en) nxt = P_IDLE;
                else if (m_t == DEAD - 1) nxt = P_ON;
            end
            P_ON: begin
                m_max = (m_t == MAX_ON - 1);
                if (!en || (ilim_s && m_t >= LEB && m_t >= MIN_ON - 1) || m_t == MAX_ON - 1) nxt = P_GAP_DN;
            end
            P_GAP_DN: if (m_t == DEAD - 1) nxt = en ? P_OFF : P_IDLE;
            default:  nxt = P_IDLE;
        endcase
        m_t     = (nxt != m_phase) ? 0 : m_t + 1;
        m_phase = nxt;
        m_hs    = (nxt == P_ON);
        m_ls    = (nxt == P_OFF);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("outputs", {20'd0, hs_on, ls_on, pwm_o, maxduty_p, skip_cnt},
              {20'd0, m_hs, m_ls, m_hs, m_max, m_skip[7:0]});
        check("no_overlap", {31'd0, hs_on & ls_on}, 32'd0);
        if (maxduty_p) max_count++;
        if (!hs_on && !ls_on) gap_run++;
        else begin
            if (gap_run > 0) last_gap = gap_run;
            gap_run = 0;
        end
        if (hs_on) hs_run++;
        else begin
            if (hs_run > 0) last_hs = hs_run;
            hs_run = 0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_for(input bit sel_ls, input logic lvl, input int budget, input string name);
        int n = 0;
        while (((sel_ls ? ls_on : hs_on) !== lvl) && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, (sel_ls ? ls_on : hs_on) === lvl}, 32'd1);
    endtask

    task automatic pulse_start();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    initial begin
        ticks(2);
        check("reset_outputs", {24'd0, hs_on, ls_on, pwm_o, maxduty_p, 4'd0}, 32'd0);
        check("reset_skip", {24'd0, skip_cnt}, 32'd0);
        RST = 1'b0;
        en  = 1'b1;
        tick();
        check("idle_to_off_ls", {31'd0, ls_on}, 32'd1);
        ticks(8);

        // Unlimited pulse runs to MAX_ON.
        max_count = 0;
        pulse_start();
        wait_for(0, 1'b1, 10, "t1_hs_rise");
        check("t1_gap_up", last_gap, DEAD);
        wait_for(0, 1'b0, 300, "t1_hs_fall");
        check("t1_hs_width", last_hs, 200);
        wait_for(1, 1'b1, 10, "t1_ls_rise");
        check("t1_gap_dn", last_gap, DEAD);
        check("t1_maxduty_pulses", max_count, 1);

        // Trip held from one cycle after hs rise: ends at the blanking/min-on floor.
        ticks(6);
        max_count = 0;
        pulse_start();
        wait_for(0, 1'b1, 10, "t2_hs_rise");
        tick();
        ilim_trip = 1'b1;
        wait_for(0, 1'b0, 50, "t2_hs_fall");
        ilim_trip = 1'b0;
        check("t2_hs_width", last_hs, 4);
        check("t2_no_maxduty", max_count, 0);

        // One-cycle trip while on-counter reads 8.
        wait_for(1, 1'b1, 10, "t3_ls_rise");
        ticks(6);
        pulse_start();
        wait_for(0, 1'b1, 10, "t3_hs_rise");
        check("t3_gap_up", last_gap, DEAD);
        ticks(8);
        ilim_trip = 1'b1;
        tick();
        ilim_trip = 1'b0;
        wait_for(0, 1'b0, 50, "t3_hs_fall");
        check("t3_hs_width", last_hs, 11);
        wait_for(1, 1'b1, 10, "t3_ls_rise2");
        check("t3_gap_dn", last_gap, DEAD);

        // Early period_start is rejected and counted; skip counter saturates.
        tick();
        pulse_start();
        check("t4_skip_one", {24'd0, skip_cnt}, 32'd1);
        ticks(2);
        pulse_start();
        wait_for(0, 1'b1, 10, "t4_accept_hs_rise");
        ilim_trip = 1'b1;
        for (int k = 0; k < 100; k++) begin
            wait_for(1, 1'b1, 40, "t4_loop_ls_rise");
            period_start = 1'b1;
            ticks(4);
            period_start = 1'b0;
        end
        ilim_trip = 1'b0;
        check("t4_skip_saturated", {24'd0, skip_cnt}, 32'd255);

        // en drop mid-ON goes through the dead gap to IDLE.
        wait_for(1, 1'b1, 300, "t5_ls_rise");
        ticks(5);
        pulse_start();
        wait_for(0, 1'b1, 10, "t5_hs_rise");
        ticks(10);
        en = 1'b0;
        tick();
        check("t5_hs_drop", {31'd0, hs_on}, 32'd0);
        check("t5_hs_width", last_hs, 11);
        ticks(4);
        check("t5_idle_outputs", {30'd0, hs_on, ls_on}, 32'd0);
        en = 1'b1;
        tick();
        check("t5_reenable_ls", {31'd0, ls_on}, 32'd1);
        ticks(3);
        en = 1'b0;
        tick();
        check("t5_off_disable_ls", {31'd0, ls_on}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            en           = ($urandom_range(0, 79) != 0);
            period_start = ($urandom_range(0, 5) == 0);
            ilim_trip    = ($urandom_range(0, 9) < 2);
            tick();
        end
        period_start = 1'b0;
        ilim_trip    = 1'b0;

        // Asynchronous reset in the middle of an on-pulse.
        en = 1'b1;
        wait_for(1, 1'b1, 300, "t6_ls_rise");
        ticks(5);
        pulse_start();
        wait_for(0, 1'b1, 10, "t6_hs_rise");
        ticks(3);
        #2;
        RST = 1'b1;
        #1;
        check("t6_async_hs", {28'd0, hs_on, ls_on, pwm_o, maxduty_p}, 32'd0);
        check("t6_async_skip", {24'd0, skip_cnt}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        check("t6_release_off", {30'd0, hs_on, ls_on}, 32'd1);
        ticks(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
